// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: one bit per cycle (shift-add / restoring divide),
// 32 iterations regardless of data, with a valid/ready request and result handshake.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic               neg_a_reg, neg_b_reg;
  logic [WIDTH-1:0]   a_mag_reg, b_mag_reg;
  logic [4:0]         cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               accept;
  logic               last_iter;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [2*WIDTH-1:0] mul_addend, acc_next, mul_final;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [WIDTH-1:0]   div_quo_final, div_rem_final;

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign out_valid = (state_reg == ST_DONE);
  assign out_hi    = hi_reg;
  assign out_lo    = lo_reg;

  assign accept    = (state_reg == ST_IDLE) && in_valid && !cancel;
  assign last_iter = (cnt_reg == 5'd31);

  // Signed ops work on magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude.
  assign op_signed = !in_op[0];
  assign a_mag_in  = (op_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
  assign b_mag_in  = (op_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;

  always_comb begin
    mul_addend = '0;
    if (b_mag_reg[cnt_reg])
      mul_addend = {{WIDTH{1'b0}}, a_mag_reg} << cnt_reg;
    acc_next  = acc_reg + mul_addend;
    mul_final = (neg_a_reg ^ neg_b_reg) ? (~acc_next + 1'b1) : acc_next;
  end

  // Dividend bits stream out of quo_reg's MSB while quotient bits enter at its LSB.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, b_mag_reg};
    q_bit     = ~|trial[WIDTH+1:WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_reg[WIDTH-2:0], q_bit};

    // With b==0 every trial succeeds, so the remainder ends as |a| and its sign fix restores in_a.
    div_rem_final = neg_a_reg ? (~rem_next + 1'b1) : rem_next;
    if (b_mag_reg == '0)
      div_quo_final = '1;
    else if (neg_a_reg ^ neg_b_reg)
      div_quo_final = ~quo_next + 1'b1;
    else
      div_quo_final = quo_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = in_op[1] ? ST_DIV : ST_MUL;
      ST_MUL:  if (last_iter) state_next = ST_DONE;
      ST_DIV:  if (last_iter) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (cancel)
      state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      a_mag_reg <= '0;
      b_mag_reg <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (accept) begin
      neg_a_reg <= op_signed && in_a[WIDTH-1];
      neg_b_reg <= op_signed && in_b[WIDTH-1];
      a_mag_reg <= a_mag_in;
      b_mag_reg <= b_mag_in;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= a_mag_in;
    end else if (state_reg == ST_MUL) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + 5'd1;
      if (last_iter && !cancel) begin
        hi_reg <= mul_final[2*WIDTH-1:WIDTH];
        lo_reg <= mul_final[WIDTH-1:0];
      end
    end else if (state_reg == ST_DIV) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg + 5'd1;
      if (last_iter && !cancel) begin
        hi_reg <= div_rem_final;
        lo_reg <= div_quo_final;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised scoreboard bench for muldiv_seq: expected {hi,lo} queued on accept, checked by a monitor.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .cancel    (cancel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; division truncates toward zero, remainder takes dividend sign.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      2'd0: begin sp = sa * sb; r = 64'(sp); end
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
               else r = {a % b, a / b};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !cancel) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", {out_hi, out_lo});
      end else begin
        mon_exp = exp_q.pop_front();
        $display("result hi=%h lo=%h expected %h", out_hi, out_lo, mon_exp);
        check("result", {out_hi, out_lo}, mon_exp);
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
    int n;
    logic [63:0] held;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
    exp_q.push_back(ref_model(op, a, b));
    $display("issue op=%0d a=%h b=%h", op, a, b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("latency", 64'(n), 64'd33);
    held = {out_hi, out_lo};
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", {out_hi, out_lo}, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_ready", 64'({out_valid, busy, in_ready}), 64'b001);
  endtask

  task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("issue (to be aborted) op=%0d a=%h b=%h", op, a, b);
    @(negedge clk);
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int sel;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_ctrl", 64'({in_ready, busy, out_valid}), 64'b100);
    check("reset_data", {out_hi, out_lo}, 64'd0);

    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd3, 32'd100, 32'd7, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'd2, 32'd8, 32'd0, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'd3, 32'h8000_0000, 32'd0, 0);
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 5);

    // Flush in the middle of a divide, then a fresh multiply must complete normally.
    start_only(2'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_ctrl", 64'({out_valid, busy, in_ready}), 64'b001);
    expect_quiet("cancel_no_valid", 40);
    do_op(2'd0, 32'h0001_2345, 32'hFFFF_FF00, 0);

    // Asynchronous reset in the middle of a multiply.
    start_only(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (19) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midreset_ctrl", 64'({out_valid, busy}), 64'd0);
    check("midreset_data", {out_hi, out_lo}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(in_ready), 64'd1);
    expect_quiet("midreset_no_valid", 40);

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 20)); end
      else if (sel == 3) rb = rb >> $urandom_range(0, 31);
      do_op(rop, ra, rb, $urandom_range(0, 3));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
